// File: rtl/reg_word_assembler_pkg.sv
// Shared types for the register word assembler: byte/word containers and FSM states.
`timescale 1ns/1ps
package reg_word_assembler_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] word_t;
  typedef logic [3:0]  reg_num_t;
  typedef logic [7:0]  timer_t;

  typedef enum logic [1:0] {
    RWA_IDLE,
    RWA_WR_REQ,
    RWA_RD_REQ
  } rwa_state_t;

endpackage

// File: rtl/reg_word_assembler.sv
// Merges byte-wide register strobes into atomic 16-bit word requests.
// Even byte is the high byte (68k order). A word read is snapshotted so the
// odd-byte read returns the low half of the same word the even-byte read saw.
`timescale 1ns/1ps
module reg_word_assembler
  import reg_word_assembler_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        write_strobe_i,
  input  logic        read_strobe_i,
  input  logic [3:0]  reg_num_i,
  input  logic        bytesel_i,
  input  logic [7:0]  bytedata_i,
  output logic        reg_wr_o,
  output logic [3:0]  reg_wr_num_o,
  output logic [15:0] reg_wr_data_o,
  input  logic        reg_wr_ack_i,
  output logic        reg_rd_o,
  output logic [3:0]  reg_rd_num_o,
  input  logic [15:0] reg_rd_data_i,
  input  logic        reg_rd_valid_i,
  output logic [7:0]  bus_data_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam timer_t TIMER_LOAD = timer_t'(ACK_TIMEOUT);

  rwa_state_t state_q, state_d;
  byte_t      hi_latch_q, hi_latch_d;
  word_t      rd_word_q, rd_word_d;
  reg_num_t   rd_num_q, rd_num_d;
  logic       rd_snap_valid_q, rd_snap_valid_d;
  reg_num_t   wr_num_q, wr_num_d;
  word_t      wr_data_q, wr_data_d;
  reg_num_t   rd_req_num_q, rd_req_num_d;
  logic       rd_sel_lo_q, rd_sel_lo_d;
  byte_t      bus_data_q, bus_data_d;
  logic       err_q, err_d;
  timer_t     timer_q, timer_d;

  // Next-state logic: strobe decode in IDLE, ack/valid/timeout handling while a request is open.
  always_comb begin
    state_d         = state_q;
    hi_latch_d      = hi_latch_q;
    rd_word_d       = rd_word_q;
    rd_num_d        = rd_num_q;
    rd_snap_valid_d = rd_snap_valid_q;
    wr_num_d        = wr_num_q;
    wr_data_d       = wr_data_q;
    rd_req_num_d    = rd_req_num_q;
    rd_sel_lo_d     = rd_sel_lo_q;
    bus_data_d      = bus_data_q;
    err_d           = err_q;
    timer_d         = timer_q;

    case (state_q)
      RWA_IDLE: begin
        if (write_strobe_i) begin
          if (read_strobe_i) begin
            err_d = 1'b1;
          end
          if (!bytesel_i) begin
            hi_latch_d      = bytedata_i;
            rd_snap_valid_d = 1'b0;
          end else begin
            wr_num_d  = reg_num_i;
            wr_data_d = {hi_latch_q, bytedata_i};
            timer_d   = TIMER_LOAD;
            state_d   = RWA_WR_REQ;
            if (reg_num_i == rd_num_q) begin
              rd_snap_valid_d = 1'b0;
            end
          end
        end else if (read_strobe_i) begin
          if (bytesel_i && rd_snap_valid_q && (reg_num_i == rd_num_q)) begin
            bus_data_d      = rd_word_q[7:0];
            rd_snap_valid_d = 1'b0;
          end else begin
            rd_req_num_d = reg_num_i;
            rd_sel_lo_d  = bytesel_i;
            timer_d      = TIMER_LOAD;
            state_d      = RWA_RD_REQ;
          end
        end
      end

      RWA_WR_REQ: begin
        if (reg_wr_ack_i) begin
          state_d = RWA_IDLE;
        end else if (timer_q <= 8'd1) begin
          state_d = RWA_IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end

      RWA_RD_REQ: begin
        if (reg_rd_valid_i) begin
          rd_word_d       = reg_rd_data_i;
          rd_num_d        = rd_req_num_q;
          // An odd-byte fetch has already consumed the low half, so no snapshot is left pending.
          rd_snap_valid_d = !rd_sel_lo_q;
          bus_data_d      = rd_sel_lo_q ? reg_rd_data_i[7:0] : reg_rd_data_i[15:8];
          state_d         = RWA_IDLE;
        end else if (timer_q <= 8'd1) begin
          state_d = RWA_IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end

      default: begin
        state_d = RWA_IDLE;
      end
    endcase

    // A strobe arriving mid-request is dropped; only the high-byte latch can still be loaded.
    if ((state_q != RWA_IDLE) && (write_strobe_i || read_strobe_i)) begin
      err_d = 1'b1;
      if (write_strobe_i && !bytesel_i) begin
        hi_latch_d = bytedata_i;
      end
    end
  end

  // State register; asynchronous reset drops any open request at once.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q         <= RWA_IDLE;
      hi_latch_q      <= '0;
      rd_word_q       <= '0;
      rd_num_q        <= '0;
      rd_snap_valid_q <= 1'b0;
      wr_num_q        <= '0;
      wr_data_q       <= '0;
      rd_req_num_q    <= '0;
      rd_sel_lo_q     <= 1'b0;
      bus_data_q      <= '0;
      err_q           <= 1'b0;
      timer_q         <= '0;
    end else begin
      state_q         <= state_d;
      hi_latch_q      <= hi_latch_d;
      rd_word_q       <= rd_word_d;
      rd_num_q        <= rd_num_d;
      rd_snap_valid_q <= rd_snap_valid_d;
      wr_num_q        <= wr_num_d;
      wr_data_q       <= wr_data_d;
      rd_req_num_q    <= rd_req_num_d;
      rd_sel_lo_q     <= rd_sel_lo_d;
      bus_data_q      <= bus_data_d;
      err_q           <= err_d;
      timer_q         <= timer_d;
    end
  end

  assign reg_wr_o      = (state_q == RWA_WR_REQ);
  assign reg_rd_o      = (state_q == RWA_RD_REQ);
  assign busy_o        = (state_q != RWA_IDLE);
  assign reg_wr_num_o  = wr_num_q;
  assign reg_wr_data_o = wr_data_q;
  assign reg_rd_num_o  = rd_req_num_q;
  assign bus_data_o    = bus_data_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_reg_word_assembler.sv
// Bench for reg_word_assembler: expected word requests are queued when strobes are
// driven and popped when the DUT raises reg_wr_o / reg_rd_o.
`timescale 1ns/1ps
module tb_reg_word_assembler;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        write_strobe_i = 1'b0;
  logic        read_strobe_i = 1'b0;
  logic [3:0]  reg_num_i = '0;
  logic        bytesel_i = 1'b0;
  logic [7:0]  bytedata_i = '0;
  logic        reg_wr_o;
  logic [3:0]  reg_wr_num_o;
  logic [15:0] reg_wr_data_o;
  logic        reg_wr_ack_i = 1'b0;
  logic        reg_rd_o;
  logic [3:0]  reg_rd_num_o;
  logic [15:0] reg_rd_data_i = '0;
  logic        reg_rd_valid_i = 1'b0;
  logic [7:0]  bus_data_o;
  logic        busy_o;
  logic        err_o;

  int checkCount = 0;
  int failCount  = 0;

  logic [19:0] wrQueue[$];
  logic [3:0]  rdQueue[$];
  logic [7:0]  modelHi = 8'h00;
  logic        wrPrev = 1'b0;
  logic        rdPrev = 1'b0;
  logic [19:0] wrExp;
  logic [3:0]  rdExp;

  reg_word_assembler #(.ACK_TIMEOUT(15)) dut (
    .clk            (clk),
    .reset_n_i      (reset_n_i),
    .write_strobe_i (write_strobe_i),
    .read_strobe_i  (read_strobe_i),
    .reg_num_i      (reg_num_i),
    .bytesel_i      (bytesel_i),
    .bytedata_i     (bytedata_i),
    .reg_wr_o       (reg_wr_o),
    .reg_wr_num_o   (reg_wr_num_o),
    .reg_wr_data_o  (reg_wr_data_o),
    .reg_wr_ack_i   (reg_wr_ack_i),
    .reg_rd_o       (reg_rd_o),
    .reg_rd_num_o   (reg_rd_num_o),
    .reg_rd_data_i  (reg_rd_data_i),
    .reg_rd_valid_i (reg_rd_valid_i),
    .bus_data_o     (bus_data_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One-cycle strobe driven on the falling edge; returns on the next falling edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic sel,
                               input logic [3:0] num, input logic [7:0] data);
    write_strobe_i = wr;
    read_strobe_i  = rd;
    bytesel_i      = sel;
    reg_num_i      = num;
    bytedata_i     = data;
    @(negedge clk);
    write_strobe_i = 1'b0;
    read_strobe_i  = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Pulse write ack for one cycle starting now (mid-cycle).
  task automatic pulseAck();
    reg_wr_ack_i = 1'b1;
    @(negedge clk);
    reg_wr_ack_i = 1'b0;
  endtask

  task automatic pulseValid(input logic [15:0] data);
    reg_rd_data_i  = data;
    reg_rd_valid_i = 1'b1;
    @(negedge clk);
    reg_rd_valid_i = 1'b0;
  endtask

  // Scoreboard monitor: each new request is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n_i) begin
      if (reg_wr_o && !wrPrev) begin
        if (wrQueue.size() == 0) begin
          checkOutput("unexpected_wr", 32'd1, 32'd0);
        end else begin
          wrExp = wrQueue.pop_front();
          checkOutput("wr_num", 32'(reg_wr_num_o), 32'(wrExp[19:16]));
          checkOutput("wr_data", 32'(reg_wr_data_o), 32'(wrExp[15:0]));
        end
      end
      if (reg_rd_o && !rdPrev) begin
        if (rdQueue.size() == 0) begin
          checkOutput("unexpected_rd", 32'd1, 32'd0);
        end else begin
          rdExp = rdQueue.pop_front();
          checkOutput("rd_num", 32'(reg_rd_num_o), 32'(rdExp));
        end
      end
    end
    wrPrev = reg_wr_o;
    rdPrev = reg_rd_o;
  end

  initial begin
    // Reset state
    #1;
    checkOutput("rst_wr", 32'(reg_wr_o), 32'd0);
    checkOutput("rst_rd", 32'(reg_rd_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    checkOutput("rst_bus", 32'(bus_data_o), 32'd0);
    checkOutput("rst_wrdata", 32'(reg_wr_data_o), 32'd0);
    waitCycles(2);
    reset_n_i = 1'b1;
    waitCycles(2);

    // Word write, ack two cycles after the request appears
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 8'hAB);
    modelHi = 8'hAB;
    checkOutput("even_wr_no_req", 32'(reg_wr_o), 32'd0);
    wrQueue.push_back({4'd3, modelHi, 8'hCD});
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, 8'hCD);
    checkOutput("wr_req_up", 32'(reg_wr_o), 32'd1);
    checkOutput("wr_busy", 32'(busy_o), 32'd1);
    waitCycles(1);
    checkOutput("wr_req_held", 32'(reg_wr_o), 32'd1);
    pulseAck();
    checkOutput("wr_req_drop", 32'(reg_wr_o), 32'd0);
    checkOutput("wr_idle", 32'(busy_o), 32'd0);

    // Ack in the first request cycle; high latch reused
    wrQueue.push_back({4'd3, modelHi, 8'h11});
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, 8'h11);
    pulseAck();
    checkOutput("fast_ack_drop", 32'(reg_wr_o), 32'd0);
    checkOutput("no_err_yet", 32'(err_o), 32'd0);

    // Snapshot read: even fetch, then odd served from snapshot
    rdQueue.push_back(4'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
    checkOutput("rd_req_up", 32'(reg_rd_o), 32'd1);
    pulseValid(16'h1234);
    checkOutput("rd_hi_byte", 32'(bus_data_o), 32'h12);
    checkOutput("rd_req_drop", 32'(reg_rd_o), 32'd0);
    reg_rd_data_i = 16'hFFFF;
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd5, 8'h00);
    checkOutput("snap_lo_byte", 32'(bus_data_o), 32'h34);
    checkOutput("snap_no_req", 32'(reg_rd_o), 32'd0);

    // Odd read of a different register fetches
    rdQueue.push_back(4'd6);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd6, 8'h00);
    checkOutput("odd_fetch_req", 32'(reg_rd_o), 32'd1);
    pulseValid(16'h5678);
    checkOutput("odd_fetch_lo", 32'(bus_data_o), 32'h78);
    waitCycles(3);
    checkOutput("bus_hold", 32'(bus_data_o), 32'h78);

    // Write to the snapshotted register invalidates it
    rdQueue.push_back(4'd7);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd7, 8'h00);
    pulseValid(16'hA1B2);
    checkOutput("snap7_hi", 32'(bus_data_o), 32'hA1);
    wrQueue.push_back({4'd7, modelHi, 8'h42});
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd7, 8'h42);
    pulseAck();
    rdQueue.push_back(4'd7);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd7, 8'h00);
    checkOutput("stale_refetch", 32'(reg_rd_o), 32'd1);
    pulseValid(16'hC3D4);
    checkOutput("stale_lo", 32'(bus_data_o), 32'hD4);

    // Strobes while busy: dropped, err sticky, even write still loads high latch
    wrQueue.push_back({4'd2, modelHi, 8'h55});
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd2, 8'h55);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd9, 8'h00);
    checkOutput("busy_err", 32'(err_o), 32'd1);
    checkOutput("busy_no_rd", 32'(reg_rd_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd2, 8'h77);
    modelHi = 8'h77;
    checkOutput("busy_still_wr", 32'(reg_wr_o), 32'd1);
    pulseAck();
    wrQueue.push_back({4'd4, modelHi, 8'h88});
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd4, 8'h88);
    pulseAck();
    checkOutput("err_sticky", 32'(err_o), 32'd1);

    // Reset mid-request drops everything immediately, nothing retried
    wrQueue.push_back({4'd1, modelHi, 8'h01});
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd1, 8'h01);
    #2;
    reset_n_i = 1'b0;
    modelHi = 8'h00;
    #1;
    checkOutput("async_wr_drop", 32'(reg_wr_o), 32'd0);
    checkOutput("async_busy", 32'(busy_o), 32'd0);
    checkOutput("async_err", 32'(err_o), 32'd0);
    checkOutput("async_bus", 32'(bus_data_o), 32'd0);
    @(negedge clk);
    reset_n_i = 1'b1;
    waitCycles(3);
    checkOutput("no_retry", 32'(reg_wr_o), 32'd0);

    // Write timeout: request high for 15 cycles, gone in cycle 16
    wrQueue.push_back({4'hA, modelHi, 8'h5A});
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hA, 8'h5A);
    for (int k = 1; k <= 15; k++) begin
      if (k == 1 || k == 15) checkOutput("to_wr_held", 32'(reg_wr_o), 32'd1);
      if (k == 15) checkOutput("to_err_pending", 32'(err_o), 32'd0);
      @(negedge clk);
    end
    checkOutput("to_wr_drop", 32'(reg_wr_o), 32'd0);
    checkOutput("to_idle", 32'(busy_o), 32'd0);
    checkOutput("to_err", 32'(err_o), 32'd1);

    // Read timeout leaves the bus byte alone
    rdQueue.push_back(4'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd1, 8'h00);
    pulseValid(16'h9A00);
    checkOutput("rd_before_to", 32'(bus_data_o), 32'h9A);
    rdQueue.push_back(4'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, 8'h00);
    waitCycles(15);
    checkOutput("to_rd_drop", 32'(reg_rd_o), 32'd0);
    checkOutput("to_rd_bus", 32'(bus_data_o), 32'h9A);

    waitCycles(2);
    checkOutput("wr_queue_empty", 32'(wrQueue.size()), 32'd0);
    checkOutput("rd_queue_empty", 32'(rdQueue.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
